// File: rtl/ucode_pkg.sv
// Shared types and widths for the micro-code store port arbiter.
// Used by the arbiter, its grant encoder and the port interface.
package ucode_pkg;

    localparam int UCODE_ADDR_W = 8;
    localparam int UCODE_DATA_W = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } ucode_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_NORM = 2'd1,
        TAG_SPEC = 2'd2
    } ucode_tag_e;

endpackage

// File: rtl/ucode_port_arbiter_if.sv
// Port bundle of the micro-code arbiter: three requesters, the memory side and
// debug visibility of the FSM state and starvation counter.
interface ucode_port_arbiter_if
    import ucode_pkg::*;
#(
    parameter int ADDR_W = UCODE_ADDR_W,
    parameter int DATA_W = UCODE_DATA_W
);
    // Handshake: a requester raises *_req with stable address/data and holds them
    // until it sees its *_gnt in the same cycle; read data returns one cycle after
    // the grant, qualified by *_valid, with no back-pressure on responses.
    logic              flush_pipeline;
    logic              norm_req;
    logic [ADDR_W-1:0] norm_addr;
    logic              norm_gnt;
    logic              norm_valid;
    logic [DATA_W-1:0] norm_rdata;
    logic              spec_req;
    logic [ADDR_W-1:0] spec_addr;
    logic              spec_gnt;
    logic              spec_valid;
    logic [DATA_W-1:0] spec_rdata;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_last;
    logic              ld_gnt;
    logic              load_active;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    ucode_state_e      state_dbg;
    logic [STARVE_CNT_W-1:0] starve_dbg;

    modport slave (
        input  flush_pipeline, norm_req, norm_addr, spec_req, spec_addr,
               ld_req, ld_addr, ld_wdata, ld_last, mem_rdata,
        output norm_gnt, norm_valid, norm_rdata, spec_gnt, spec_valid, spec_rdata,
               ld_gnt, load_active, mem_en, mem_we, mem_addr, mem_wdata,
               state_dbg, starve_dbg
    );

    modport master (
        output flush_pipeline, norm_req, norm_addr, spec_req, spec_addr,
               ld_req, ld_addr, ld_wdata, ld_last, mem_rdata,
        input  norm_gnt, norm_valid, norm_rdata, spec_gnt, spec_valid, spec_rdata,
               ld_gnt, load_active, mem_en, mem_we, mem_addr, mem_wdata,
               state_dbg, starve_dbg
    );

endinterface

// File: rtl/ucode_prio_select.sv
// Fixed-priority grant encoder: starved loader, normal fetch, speculative fetch,
// then loader; in LOAD mode the loader owns the port exclusively.
module ucode_prio_select (
    input  logic rst_i,
    input  logic load_mode_i,
    input  logic starve_hit_i,
    input  logic flush_i,
    input  logic norm_req_i,
    input  logic spec_req_i,
    input  logic ld_req_i,
    output logic norm_gnt_o,
    output logic spec_gnt_o,
    output logic ld_gnt_o
);

    always_comb begin
        norm_gnt_o = 1'b0;
        spec_gnt_o = 1'b0;
        ld_gnt_o   = 1'b0;
        if (rst_i) begin
            ld_gnt_o = 1'b0;
        end else if (load_mode_i) begin
            ld_gnt_o = ld_req_i;
        end else if (starve_hit_i) begin
            ld_gnt_o = 1'b1;
        end else if (norm_req_i) begin
            norm_gnt_o = 1'b1;
        end else if (spec_req_i && !flush_i) begin
            // A flush cancels only the speculative request of this cycle.
            spec_gnt_o = 1'b1;
        end else if (ld_req_i) begin
            ld_gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/ucode_port_arbiter.sv
// Shares the single-port micro-code store between normal fetch, speculative fetch
// and the loader; a RUN/LOAD FSM keeps reads off a partially loaded program.
module ucode_port_arbiter
    import ucode_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    ucode_port_arbiter_if.slave bus
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    ucode_state_e              state_q, state_d;
    ucode_tag_e                resp_tag_q, resp_tag_d;
    logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic                      norm_gnt, spec_gnt, ld_gnt;
    logic                      starve_hit;

    assign starve_hit = bus.ld_req && (starve_cnt_q == STARVE_LIM);

    ucode_prio_select u_prio_select (
        .rst_i        (rst),
        .load_mode_i  (state_q == ST_LOAD),
        .starve_hit_i (starve_hit),
        .flush_i      (bus.flush_pipeline),
        .norm_req_i   (bus.norm_req),
        .spec_req_i   (bus.spec_req),
        .ld_req_i     (bus.ld_req),
        .norm_gnt_o   (norm_gnt),
        .spec_gnt_o   (spec_gnt),
        .ld_gnt_o     (ld_gnt)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && ld_gnt && !bus.ld_last) begin
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD && ld_gnt && bus.ld_last) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ld_gnt || !bus.ld_req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        resp_tag_d = TAG_NONE;
        if (norm_gnt) begin
            resp_tag_d = TAG_NORM;
        end else if (spec_gnt) begin
            resp_tag_d = TAG_SPEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            resp_tag_q   <= TAG_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_tag_q   <= resp_tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.norm_gnt    = norm_gnt;
    assign bus.spec_gnt    = spec_gnt;
    assign bus.ld_gnt      = ld_gnt;
    assign bus.mem_en      = norm_gnt | spec_gnt | ld_gnt;
    assign bus.mem_we      = ld_gnt;
    assign bus.mem_addr    = ld_gnt   ? bus.ld_addr   :
                             spec_gnt ? bus.spec_addr :
                             norm_gnt ? bus.norm_addr : '0;
    assign bus.mem_wdata   = ld_gnt ? bus.ld_wdata : '0;

    // A flush in the return cycle kills whichever response is in flight.
    assign bus.norm_valid  = (resp_tag_q == TAG_NORM) && !bus.flush_pipeline;
    assign bus.spec_valid  = (resp_tag_q == TAG_SPEC) && !bus.flush_pipeline;
    assign bus.norm_rdata  = bus.mem_rdata;
    assign bus.spec_rdata  = bus.mem_rdata;
    assign bus.load_active = (state_q == ST_LOAD);

    assign bus.state_dbg   = state_q;
    assign bus.starve_dbg  = starve_cnt_q;

endmodule

// File: tb/tb_ucode_port_arbiter.sv
// Directed bench for ucode_port_arbiter: grants checked per cycle, read data
// checked by a monitor against queues of expected responses.
module tb_ucode_port_arbiter;
    import ucode_pkg::*;

    localparam logic [4:0] G_NONE = 5'b00000;  // {norm, spec, ld, mem_en, mem_we}
    localparam logic [4:0] G_NORM = 5'b10010;
    localparam logic [4:0] G_SPEC = 5'b01010;
    localparam logic [4:0] G_LD   = 5'b00111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] exp_norm_q[$];
    logic [31:0] exp_spec_q[$];
    logic [31:0] mem [256];
    logic [31:0] rdata_r = '0;

    ucode_port_arbiter_if bus ();

    ucode_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: 1-cycle read latency, write on the grant edge
    assign bus.mem_rdata = rdata_r;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_r <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.norm_valid === 1'b1) begin
            if (exp_norm_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL norm_valid_unexpected: got valid rdata %h, expected no response", bus.norm_rdata);
            end else begin
                chk("norm_rdata", bus.norm_rdata, exp_norm_q.pop_front());
            end
        end
        if (bus.spec_valid === 1'b1) begin
            if (exp_spec_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spec_valid_unexpected: got valid rdata %h, expected no response", bus.spec_rdata);
            end else begin
                chk("spec_rdata", bus.spec_rdata, exp_spec_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic drive(input logic n, input logic [7:0] na, input logic s, input logic [7:0] sa,
                         input logic l, input logic [7:0] la, input logic [31:0] lw,
                         input logic ll, input logic fl);
        bus.norm_req       = n;
        bus.norm_addr      = na;
        bus.spec_req       = s;
        bus.spec_addr      = sa;
        bus.ld_req         = l;
        bus.ld_addr        = la;
        bus.ld_wdata       = lw;
        bus.ld_last        = ll;
        bus.flush_pipeline = fl;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    endtask

    // one cycle: check grants (and optionally load_active / starve count), then advance
    task automatic cyc(input string name, input logic [4:0] gnt_exp, input int la_exp, input int sc_exp);
        @(negedge clk);
        chk({name, "_gnt"}, {27'd0, bus.norm_gnt, bus.spec_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we},
            {27'd0, gnt_exp});
        if (la_exp >= 0) chk({name, "_load_active"}, {31'd0, bus.load_active}, 32'(la_exp));
        if (sc_exp >= 0) chk({name, "_starve"}, {28'd0, bus.starve_dbg}, 32'(sc_exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFEF00D;

        // reset with every request raised
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("rst0", G_NONE, -1, -1);
        cyc("rst1", G_NONE, 0, 0);
        rst = 1'b0;
        exp_norm_q.push_back(32'hDEADBEEF);
        cyc("post_rst", G_NORM, 0, 0);
        idle();
        cyc("post_rst_idle", G_NONE, 0, 1);

        // normal vs speculative contention
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        exp_norm_q.push_back(32'hDEADBEEF);
        cyc("cont_norm", G_NORM, 0, 0);
        drive(1'b0, 8'h10, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        exp_spec_q.push_back(32'hCAFEF00D);
        cyc("cont_spec", G_SPEC, 0, -1);
        idle();
        cyc("cont_idle", G_NONE, 0, -1);

        // flush: in-flight spec response killed, held spec_req blocked, normal unaffected
        drive(1'b0, 8'h10, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        cyc("flush_spec", G_SPEC, 0, -1);
        drive(1'b0, 8'h10, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
        cyc("flush_block", G_NONE, 0, -1);
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
        exp_norm_q.push_back(32'hDEADBEEF);
        cyc("flush_norm", G_NORM, 0, -1);
        idle();
        cyc("flush_idle", G_NONE, 0, -1);

        // starvation: loader forced ahead of normal fetch on the 5th cycle
        drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 8'h00, 32'h11111111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_norm_q.push_back(32'hDEADBEEF);
            cyc("starve_norm", G_NORM, 0, i);
        end
        cyc("starve_ld", G_LD, 0, 4);

        // rest of the burst, with a one-cycle loader gap inside LOAD
        drive(1'b1, 8'h02, 1'b1, 8'h20, 1'b1, 8'h01, 32'h22222222, 1'b0, 1'b0);
        cyc("burst_w1", G_LD, 1, 0);
        drive(1'b1, 8'h02, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        cyc("burst_gap", G_NONE, 1, 0);
        drive(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 8'h02, 32'h33333333, 1'b1, 1'b0);
        cyc("burst_w2", G_LD, 1, 0);
        drive(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        exp_norm_q.push_back(32'h33333333);
        cyc("burst_read", G_NORM, 0, 0);
        idle();
        cyc("burst_idle", G_NONE, 0, -1);

        // single-word load stays in RUN
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05, 32'h55555555, 1'b1, 1'b0);
        cyc("single_ld", G_LD, 0, -1);
        drive(1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        exp_norm_q.push_back(32'h55555555);
        cyc("single_read", G_NORM, 0, -1);
        idle();
        cyc("single_idle", G_NONE, 0, -1);

        // reset in the middle of a burst abandons it
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h06, 32'h66666666, 1'b0, 1'b0);
        cyc("mb_ld", G_LD, 0, -1);
        drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        cyc("mb_blocked", G_NONE, 1, -1);
        rst = 1'b1;
        cyc("mb_rst", G_NONE, 1, -1);
        rst = 1'b0;
        exp_norm_q.push_back(32'hDEADBEEF);
        cyc("mb_after", G_NORM, 0, 0);
        idle();
        cyc("mb_idle", G_NONE, 0, -1);
        cyc("drain", G_NONE, 0, -1);

        chk("norm_queue_left", 32'(exp_norm_q.size()), 32'd0);
        chk("spec_queue_left", 32'(exp_spec_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
